instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 10'd0, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 16'h0000, meaning the bubble word driven to the decoder; opcode 6'b000000 decodes to all-disabled.
REQ-003 SHALL have parameter HALT_OPCODE, default 6'b111111, meaning the opcode that stops fetch.
REQ-004 SHALL have port iClock, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-005 SHALL have port iReset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port iStall, input, 1 bit: hold the PC and the IF/ID register.
REQ-007 SHALL have port iFlush, input, 1 bit: load a bubble into IF/ID.
REQ-008 SHALL have port iBranchTaken, input, 1 bit: redirect the PC to iBranchTarget.
REQ-009 SHALL have port iBranchTarget, input, 10 bits: the redirect address.
REQ-010 SHALL have port oInstrAddr, output, 10 bits: the instruction ROM address, equal to the current PC.
REQ-011 SHALL have port iInstrData, input, 16 bits: ROM data for oInstrAddr, valid in the same cycle (combinational ROM).
REQ-012 SHALL have port oMemoryMicrocode, output, 16 bits: the IF/ID instruction word, feeding decoder iMemoryMicrocode.
REQ-013 SHALL have port oPC, output, 10 bits: the address of the word held in IF/ID.
REQ-014 SHALL have port oValid, output, 1 bit: IF/ID holds a real instruction, not a bubble.
REQ-015 SHALL have port oHalted, output, 1 bit: fetch is stopped in HALT.

Function
REQ-016 SHALL implement FSM states RESET, FETCH and HALT.
REQ-017 SHALL spend exactly one cycle in RESET after reset release, holding PC at RESET_PC, loading a bubble into IF/ID, and moving to FETCH regardless of other inputs.
REQ-018 SHALL, in FETCH with no stall, flush or branch, capture iInstrData into oMemoryMicrocode, capture the PC into oPC, set oValid=1, and advance PC to PC+1; latency from address to oMemoryMicrocode is 1 cycle.
REQ-019 SHALL wrap PC arithmetic modulo 2^10, so that 10'd1023 + 1 = 10'd0.
REQ-020 SHALL apply priority reset > iBranchTaken > iFlush > iStall > normal fetch.
REQ-021 SHALL, on iBranchTaken, set PC to iBranchTarget and load a bubble (NOP_WORD, oValid=0) into IF/ID, even when iStall=1.
REQ-022 SHALL, on iFlush without a branch, load a bubble into IF/ID; PC advances if iStall=0 and holds if iStall=1.
REQ-023 SHALL, on iStall alone, hold PC, oMemoryMicrocode, oPC and oValid unchanged.
REQ-024 SHALL, in FETCH, when a word with iInstrData[15:10]==HALT_OPCODE is captured, latch that word normally, hold PC, and enter HALT.
REQ-025 SHALL NOT capture a HALT word in a stall, flush or branch cycle, and SHALL NOT enter HALT in that cycle.
REQ-026 SHALL, in HALT, hold PC, load a bubble into IF/ID every cycle, and drive oHalted=1; iStall and iFlush have no effect there.
REQ-027 SHALL, on iBranchTaken in HALT, apply REQ-021 and return to FETCH, so that a halt fetched on a wrong path is cancelled.
REQ-028 SHALL drive oInstrAddr combinationally from the PC register.

Reset
REQ-029 SHALL, while iReset_n=0 (asynchronously, including mid-stall or mid-branch), force: PC=RESET_PC, oMemoryMicrocode=NOP_WORD, oPC=0, oValid=0, oHalted=0, state=RESET.
REQ-030 SHALL ignore all other inputs while reset is asserted.

Configuration
REQ-031 SHALL, when macro HALT_DETECT_EN is defined, implement REQ-024 to REQ-027.
REQ-032 SHALL, when HALT_DETECT_EN is undefined, omit the HALT state, treat HALT_OPCODE words as ordinary instructions, and tie oHalted to 0.

Verification
REQ-033 SHALL be verified by: reset release with RESET_PC=0 and ROM[n]=n+16'h0400 -> cycle 1 bubble, then oMemoryMicrocode=16'h0400,16'h0401,... with oPC=0,1,... and oValid=1.
REQ-034 SHALL be verified by: iStall=1 for 3 cycles at PC=5 -> oInstrAddr stays 5 and the IF/ID outputs are frozen; release -> fetch resumes at 5.
REQ-035 SHALL be verified by: iBranchTaken=1, iBranchTarget=10'd200, iStall=1 in the same cycle -> next cycle oValid=0 and oMemoryMicrocode=16'h0000, oInstrAddr=200; the following cycle oPC=200.
REQ-036 SHALL be verified by: PC=1023 with normal fetch -> oPC=1023, and the next oInstrAddr=0.
REQ-037 SHALL be verified by: ROM[7]=16'hFC00 with HALT_DETECT_EN defined -> oPC=7 and oValid=1, then bubbles with oHalted=1 and oInstrAddr held at 7; iBranchTaken to 30 -> oHalted=0 and fetch resumes at 30; without HALT_DETECT_EN -> oInstrAddr advances to 8.
REQ-038 SHALL be verified by: iReset_n pulled low mid-branch between clock edges -> outputs reach their reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch FSM.
// Optional halt detection is compiled in when HALT_DETECT_EN is defined; without
// it the HALT state is absent, halt opcodes fetch as ordinary words, oHalted=0.
module instruction_fetch #(
    parameter logic [9:0]  RESET_PC    = 10'd0,
    parameter logic [15:0] NOP_WORD    = 16'h0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic        iStall,
    input  logic        iFlush,
    input  logic        iBranchTaken,
    input  logic [9:0]  iBranchTarget,
    output logic [9:0]  oInstrAddr,
    input  logic [15:0] iInstrData,
    output logic [15:0] oMemoryMicrocode,
    output logic [9:0]  oPC,
    output logic        oValid,
    output logic        oHalted
);

    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 6;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1
`ifdef HALT_DETECT_EN
        ,
        S_HALT  = 2'd2
`endif
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   pc, pc_n;
    logic [DW-1:0]   ir, ir_n;
    logic [AW-1:0]   opc, opc_n;
    logic            valid, valid_n;
    logic            halted, halted_n;

`ifdef HALT_DETECT_EN
    logic            halt_word;
    assign halt_word = (iInstrData[DW-1:DW-OPW] == HALT_OPCODE);
`else
    logic            unused_halt;
    assign unused_halt = ^HALT_OPCODE;
`endif

    // ROM address is the live PC register
    assign oInstrAddr       = pc;
    assign oMemoryMicrocode = ir;
    assign oPC              = opc;
    assign oValid           = valid;
    assign oHalted          = halted;

    // State, PC and IF/ID registers with asynchronous reset
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state  <= S_RESET;
            pc     <= RESET_PC;
            ir     <= NOP_WORD;
            opc    <= AW'(0);
            valid  <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            ir     <= ir_n;
            opc    <= opc_n;
            valid  <= valid_n;
            halted <= halted_n;
        end
    end

    // Next state and next register values; priority branch > flush > stall > fetch
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ir_n     = ir;
        opc_n    = opc;
        valid_n  = valid;
        halted_n = 1'b0;

        case (state)
            S_RESET: begin
                pc_n    = RESET_PC;
                ir_n    = NOP_WORD;
                valid_n = 1'b0;
                state_n = S_FETCH;
            end
            S_FETCH: begin
                if (iBranchTaken) begin
                    pc_n    = iBranchTarget;
                    ir_n    = NOP_WORD;
                    valid_n = 1'b0;
                end else if (iFlush) begin
                    ir_n    = NOP_WORD;
                    valid_n = 1'b0;
                    if (!iStall) begin
                        pc_n = AW'(pc + AW'(1));
                    end
                end else if (!iStall) begin
                    ir_n    = iInstrData;
                    opc_n   = pc;
                    valid_n = 1'b1;
                    pc_n    = AW'(pc + AW'(1));
`ifdef HALT_DETECT_EN
                    // Halt word is latched normally but the PC stays on it
                    if (halt_word) begin
                        pc_n    = pc;
                        state_n = S_HALT;
                    end
`endif
                end
            end
`ifdef HALT_DETECT_EN
            S_HALT: begin
                ir_n    = NOP_WORD;
                valid_n = 1'b0;
                // A branch cancels a halt fetched on a wrong path
                if (iBranchTaken) begin
                    pc_n    = iBranchTarget;
                    state_n = S_FETCH;
                end
            end
`endif
            default: begin
                state_n = S_RESET;
            end
        endcase

`ifdef HALT_DETECT_EN
        halted_n = (state_n == S_HALT);
`endif
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized stall/flush/branch traffic against a behavioural fetch model.
module tb_instruction_fetch;

    localparam logic [9:0]  RESET_PC = 10'd0;
    localparam logic [15:0] NOP_WORD = 16'h0000;
    localparam logic [5:0]  HALT_OP  = 6'b111111;
`ifdef HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        iClock;
    logic        iReset_n;
    logic        iStall;
    logic        iFlush;
    logic        iBranchTaken;
    logic [9:0]  iBranchTarget;
    logic [9:0]  oInstrAddr;
    logic [15:0] iInstrData;
    logic [15:0] oMemoryMicrocode;
    logic [9:0]  oPC;
    logic        oValid;
    logic        oHalted;

    logic [15:0] rom [1024];

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = reset cycle pending, 1 = fetching, 2 = halted
    int          m_mode;
    logic [9:0]  m_pc;
    logic [15:0] m_ir;
    logic [9:0]  m_opc;
    logic        m_valid;
    logic        m_halted;

    instruction_fetch #(
        .RESET_PC   (RESET_PC),
        .NOP_WORD   (NOP_WORD),
        .HALT_OPCODE(HALT_OP)
    ) dut (
        .iClock          (iClock),
        .iReset_n        (iReset_n),
        .iStall          (iStall),
        .iFlush          (iFlush),
        .iBranchTaken    (iBranchTaken),
        .iBranchTarget   (iBranchTarget),
        .oInstrAddr      (oInstrAddr),
        .iInstrData      (iInstrData),
        .oMemoryMicrocode(oMemoryMicrocode),
        .oPC             (oPC),
        .oValid          (oValid),
        .oHalted         (oHalted)
    );

    // Combinational ROM
    assign iInstrData = rom[oInstrAddr];

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_pc     = RESET_PC;
        m_ir     = NOP_WORD;
        m_opc    = 10'd0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic bubble();
        m_ir    = NOP_WORD;
        m_valid = 1'b0;
    endtask

    // One clock of fetch behaviour, straight from the priority rules
    task automatic model_step(input logic st, input logic fl, input logic br, input logic [9:0] tgt);
        logic [15:0] w;
        w = rom[m_pc];
        if (m_mode == 0) begin
            m_pc = RESET_PC;
            bubble();
            m_mode = 1;
        end else if (m_mode == 2) begin
            bubble();
            if (br) begin
                m_pc   = tgt;
                m_mode = 1;
            end
        end else begin
            if (br) begin
                m_pc = tgt;
                bubble();
            end else if (fl) begin
                bubble();
                if (!st) m_pc = 10'((m_pc + 1) % 1024);
            end else if (!st) begin
                m_ir    = w;
                m_opc   = m_pc;
                m_valid = 1'b1;
                if (HALT_EN && w[15:10] == HALT_OP) m_mode = 2;
                else m_pc = 10'((m_pc + 1) % 1024);
            end
        end
        m_halted = (m_mode == 2);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".addr"},   16'(oInstrAddr), 16'(m_pc));
        check({tag, ".instr"},  oMemoryMicrocode, m_ir);
        check({tag, ".valid"},  16'(oValid), 16'(m_valid));
        check({tag, ".halted"}, 16'(oHalted), 16'(m_halted));
        if (m_valid) check({tag, ".pc"}, 16'(oPC), 16'(m_opc));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".addr"},   16'(oInstrAddr), 16'(RESET_PC));
        check({tag, ".instr"},  oMemoryMicrocode, NOP_WORD);
        check({tag, ".pc"},     16'(oPC), 16'h0000);
        check({tag, ".valid"},  16'(oValid), 16'h0000);
        check({tag, ".halted"}, 16'(oHalted), 16'h0000);
    endtask

    // Called at posedge+1: drive inputs, advance model, clock, compare
    task automatic step(input logic st, input logic fl, input logic br, input logic [9:0] tgt);
        iStall        = st;
        iFlush        = fl;
        iBranchTaken  = br;
        iBranchTarget = tgt;
        model_step(st, fl, br, tgt);
        @(posedge iClock);
        #1;
        compare_all("step");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 16'(i + 16'h0400);
        iStall        = 1'b0;
        iFlush        = 1'b0;
        iBranchTaken  = 1'b0;
        iBranchTarget = 10'd0;
        iReset_n      = 1'b1;
        #1 iReset_n   = 1'b0;
        model_reset();
        #1;
        check_reset_values("reset");

        @(posedge iClock);
        #1;
        iReset_n = 1'b1;

        // Reset cycle yields a bubble, then sequential fetch
        step(0, 0, 0, 10'd0);
        check("first_bubble", 16'(oValid), 16'h0000);
        step(0, 0, 0, 10'd0);
        check("first_word", oMemoryMicrocode, 16'h0400);
        check("first_pc", 16'(oPC), 16'h0000);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 10'd0);
        check("seq_word4", oMemoryMicrocode, 16'h0404);

        // Stall for three cycles at PC=5
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 10'd0);
            check("stall_addr", 16'(oInstrAddr), 16'd5);
            check("stall_word", oMemoryMicrocode, 16'h0404);
        end
        step(0, 0, 0, 10'd0);
        check("resume_pc", 16'(oPC), 16'd5);
        check("resume_word", oMemoryMicrocode, 16'h0405);

        // Branch wins over stall
        step(1, 0, 1, 10'd200);
        check("br_valid", 16'(oValid), 16'h0000);
        check("br_word", oMemoryMicrocode, 16'h0000);
        check("br_addr", 16'(oInstrAddr), 16'd200);
        step(0, 0, 0, 10'd0);
        check("br_pc", 16'(oPC), 16'd200);

        // Flush alone: bubble, PC advances
        step(0, 1, 0, 10'd0);
        check("flush_valid", 16'(oValid), 16'h0000);
        check("flush_addr", 16'(oInstrAddr), 16'd202);

        // PC wrap at 1023
        step(0, 0, 1, 10'd1023);
        step(0, 0, 0, 10'd0);
        check("wrap_pc", 16'(oPC), 16'd1023);
        check("wrap_addr", 16'(oInstrAddr), 16'd0);

        // Halt opcode at address 7
        rom[7] = 16'hFC00;
        step(0, 0, 1, 10'd7);
        step(0, 0, 0, 10'd0);
        check("halt_pc", 16'(oPC), 16'd7);
        check("halt_valid", 16'(oValid), 16'h0001);
`ifdef HALT_DETECT_EN
        step(0, 0, 0, 10'd0);
        check("halted_flag", 16'(oHalted), 16'h0001);
        check("halted_valid", 16'(oValid), 16'h0000);
        check("halted_addr", 16'(oInstrAddr), 16'd7);
        step(1, 1, 0, 10'd0);
        check("halted_hold", 16'(oInstrAddr), 16'd7);
        step(0, 0, 1, 10'd30);
        check("unhalt_flag", 16'(oHalted), 16'h0000);
        check("unhalt_addr", 16'(oInstrAddr), 16'd30);
        step(0, 0, 0, 10'd0);
        check("unhalt_pc", 16'(oPC), 16'd30);
`else
        check("nohalt_addr", 16'(oInstrAddr), 16'd8);
        check("nohalt_flag", 16'(oHalted), 16'h0000);
`endif

        // Randomized traffic with random ROM contents and sprinkled halt words
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(0, 7) == 0) rom[i] = {HALT_OP, 10'($urandom)};
            else rom[i] = 16'($urandom);
        end
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0, 10'($urandom));
        end

        // Asynchronous reset asserted mid-branch, between clock edges
        iBranchTaken  = 1'b1;
        iBranchTarget = 10'd123;
        iStall        = 1'b1;
        #2 iReset_n   = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge iClock);
        #1;
        check_reset_values("held_reset");
        iReset_n = 1'b1;
        step(0, 0, 0, 10'd0);
        for (int n = 0; n < 20; n++) step(0, 0, 0, 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
